// File: rtl/mips32.sv
// Five-stage pipelined MIPS32 subset core (add/sub/and/or/slt/lw/sw/beq) with EX forwarding,
// no hazard stalls or flushes; every pipeline register is exported for observation.
module mips32 #(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64,
   parameter     IMEM_FILE  = "imem.mem"
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] IFID_pc4,
   output logic [31:0] IFID_inst,
   output logic [1:0]  ID_alu_op,
   output logic [31:0] IDEX_pc4,
   output logic [31:0] IDEX_ReadData1,
   output logic [31:0] IDEX_ReadData2,
   output logic [31:0] IDEX_SignExtend,
   output logic [4:0]  IDEX_inst25_21,
   output logic [4:0]  IDEX_inst20_16,
   output logic [4:0]  IDEX_inst15_11,
   output logic        fu_mem_RegWrite,
   output logic        fu_wb_RegWrite,
   output logic [4:0]  fu_ex_instr25_21,
   output logic [4:0]  fu_ex_instr20_16,
   output logic [4:0]  fu_mem_instr15_11,
   output logic [4:0]  fu_wb_instr15_11,
   output logic [1:0]  EX_alu_op,
   output logic [1:0]  ForwardA,
   output logic [1:0]  ForwardB,
   output logic [3:0]  alu_ctrl,
   output logic [31:0] ALU_input1,
   output logic [31:0] ALU_input2,
   output logic [31:0] EXMEM_PC_beq,
   output logic [31:0] EXMEM_alu_result,
   output logic [31:0] EXMEM_ReadData2,
   output logic [4:0]  EXMEM_WriteRegister,
   output logic [31:0] MEMWB_ReadData,
   output logic [31:0] MEMWB_alu_result,
   output logic [4:0]  MEMWB_WriteRegister,
   output logic [31:0] pc_out
);
   // Memory depths are powers of two, so the modulo index is a plain slice.
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] rf_q [32];
   logic [31:0] dmem_q [DMEM_DEPTH];

   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc4_q, ifid_inst_q;
   logic [31:0] idex_pc4_q, idex_rd1_q, idex_rd2_q, idex_sext_q;
   logic [4:0]  idex_rs_q, idex_rt_q, idex_rd_q;
   logic        idex_regdst_q, idex_alusrc_q, idex_memtoreg_q, idex_regwrite_q;
   logic        idex_memwrite_q, idex_branch_q;
   logic [1:0]  idex_aluop_q;
   logic [31:0] exmem_pcbeq_q, exmem_alu_q, exmem_wdata_q;
   logic [4:0]  exmem_wreg_q;
   logic        exmem_zero_q, exmem_regwrite_q, exmem_memtoreg_q, exmem_memwrite_q, exmem_branch_q;
   logic [31:0] memwb_rdata_q, memwb_alu_q;
   logic [4:0]  memwb_wreg_q;
   logic        memwb_regwrite_q, memwb_memtoreg_q;

   function automatic logic [3:0] alu_ctrl_f(input logic [1:0] op, input logic [5:0] funct);
      case (op)
         2'b00:   return 4'b0010;
         2'b01:   return 4'b0110;
         default: begin
            case (funct)
               6'h22:   return 4'b0110;
               6'h24:   return 4'b0000;
               6'h25:   return 4'b0001;
               6'h2A:   return 4'b0111;
               default: return 4'b0010;
            endcase
         end
      endcase
   endfunction

   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic signed [31:0] a,
                                         input logic signed [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0110: return a - b;
         4'b0111: return {31'd0, a < b};
         default: return a + b;
      endcase
   endfunction

   // IF
   logic [31:0] if_inst;
   assign if_inst = imem[pc_q[IAW+1:2]];
   assign pc_d    = (exmem_branch_q && exmem_zero_q) ? exmem_pcbeq_q : pc_q + 32'd4;

   // ID: decode and register read with write-through from WB
   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memwrite, id_branch;
   logic [1:0]  id_aluop;
   logic [31:0] id_rd1, id_rd2, wb_data;
   logic        wb_we;

   assign id_op = ifid_inst_q[31:26];
   assign id_rs = ifid_inst_q[25:21];
   assign id_rt = ifid_inst_q[20:16];
   assign id_rd = ifid_inst_q[15:11];

   always_comb begin
      id_regdst   = 1'b0;
      id_alusrc   = 1'b0;
      id_memtoreg = 1'b0;
      id_regwrite = 1'b0;
      id_memwrite = 1'b0;
      id_branch   = 1'b0;
      id_aluop    = 2'b00;
      case (id_op)
         6'h00: begin id_regdst = 1'b1; id_regwrite = 1'b1; id_aluop = 2'b10; end
         6'h23: begin id_alusrc = 1'b1; id_memtoreg = 1'b1; id_regwrite = 1'b1; end
         6'h2B: begin id_alusrc = 1'b1; id_memwrite = 1'b1; end
         6'h04: begin id_branch = 1'b1; id_aluop = 2'b01; end
         default: ;
      endcase
   end

   assign wb_data = memwb_memtoreg_q ? memwb_rdata_q : memwb_alu_q;
   assign wb_we   = memwb_regwrite_q && (memwb_wreg_q != 5'd0);
   assign id_rd1  = (wb_we && memwb_wreg_q == id_rs) ? wb_data : rf_q[id_rs];
   assign id_rd2  = (wb_we && memwb_wreg_q == id_rt) ? wb_data : rf_q[id_rt];

   // EX: forwarding, ALU, branch target
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] fwd_a_val, fwd_b_val, alu_in2, alu_res, ex_pcbeq;
   logic [3:0]  ex_ctrl;
   logic [4:0]  ex_wreg;

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (exmem_regwrite_q && exmem_wreg_q != 5'd0 && exmem_wreg_q == idex_rs_q)
         fwd_a = 2'b10;
      else if (wb_we && memwb_wreg_q == idex_rs_q)
         fwd_a = 2'b01;
      if (exmem_regwrite_q && exmem_wreg_q != 5'd0 && exmem_wreg_q == idex_rt_q)
         fwd_b = 2'b10;
      else if (wb_we && memwb_wreg_q == idex_rt_q)
         fwd_b = 2'b01;
   end

   assign fwd_a_val = (fwd_a == 2'b10) ? exmem_alu_q : (fwd_a == 2'b01) ? wb_data : idex_rd1_q;
   assign fwd_b_val = (fwd_b == 2'b10) ? exmem_alu_q : (fwd_b == 2'b01) ? wb_data : idex_rd2_q;
   assign alu_in2   = idex_alusrc_q ? idex_sext_q : fwd_b_val;
   assign ex_ctrl   = alu_ctrl_f(idex_aluop_q, idex_sext_q[5:0]);
   assign alu_res   = alu_f(ex_ctrl, fwd_a_val, alu_in2);
   assign ex_wreg   = idex_regdst_q ? idex_rd_q : idex_rt_q;
   assign ex_pcbeq  = idex_pc4_q + (idex_sext_q << 2);

   // MEM: combinational read
   logic [31:0] mem_rdata;
   assign mem_rdata = dmem_q[exmem_alu_q[DAW+1:2]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q             <= '0;
         ifid_pc4_q       <= '0;
         ifid_inst_q      <= '0;
         idex_pc4_q       <= '0;
         idex_rd1_q       <= '0;
         idex_rd2_q       <= '0;
         idex_sext_q      <= '0;
         idex_rs_q        <= '0;
         idex_rt_q        <= '0;
         idex_rd_q        <= '0;
         idex_regdst_q    <= 1'b0;
         idex_alusrc_q    <= 1'b0;
         idex_memtoreg_q  <= 1'b0;
         idex_regwrite_q  <= 1'b0;
         idex_memwrite_q  <= 1'b0;
         idex_branch_q    <= 1'b0;
         idex_aluop_q     <= '0;
         exmem_pcbeq_q    <= '0;
         exmem_alu_q      <= '0;
         exmem_wdata_q    <= '0;
         exmem_wreg_q     <= '0;
         exmem_zero_q     <= 1'b0;
         exmem_regwrite_q <= 1'b0;
         exmem_memtoreg_q <= 1'b0;
         exmem_memwrite_q <= 1'b0;
         exmem_branch_q   <= 1'b0;
         memwb_rdata_q    <= '0;
         memwb_alu_q      <= '0;
         memwb_wreg_q     <= '0;
         memwb_regwrite_q <= 1'b0;
         memwb_memtoreg_q <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         ifid_pc4_q       <= pc_q + 32'd4;
         ifid_inst_q      <= if_inst;
         idex_pc4_q       <= ifid_pc4_q;
         idex_rd1_q       <= id_rd1;
         idex_rd2_q       <= id_rd2;
         idex_sext_q      <= {{16{ifid_inst_q[15]}}, ifid_inst_q[15:0]};
         idex_rs_q        <= id_rs;
         idex_rt_q        <= id_rt;
         idex_rd_q        <= id_rd;
         idex_regdst_q    <= id_regdst;
         idex_alusrc_q    <= id_alusrc;
         idex_memtoreg_q  <= id_memtoreg;
         idex_regwrite_q  <= id_regwrite;
         idex_memwrite_q  <= id_memwrite;
         idex_branch_q    <= id_branch;
         idex_aluop_q     <= id_aluop;
         exmem_pcbeq_q    <= ex_pcbeq;
         exmem_alu_q      <= alu_res;
         exmem_wdata_q    <= fwd_b_val;
         exmem_wreg_q     <= ex_wreg;
         exmem_zero_q     <= (alu_res == 32'd0);
         exmem_regwrite_q <= idex_regwrite_q;
         exmem_memtoreg_q <= idex_memtoreg_q;
         exmem_memwrite_q <= idex_memwrite_q;
         exmem_branch_q   <= idex_branch_q;
         memwb_rdata_q    <= mem_rdata;
         memwb_alu_q      <= exmem_alu_q;
         memwb_wreg_q     <= exmem_wreg_q;
         memwb_regwrite_q <= exmem_regwrite_q;
         memwb_memtoreg_q <= exmem_memtoreg_q;
      end
   end

   // Register file and data RAM reload their identity images on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'(i);
      end else if (wb_we) begin
         rf_q[memwb_wreg_q] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'(i);
      end else if (exmem_memwrite_q) begin
         dmem_q[exmem_alu_q[DAW+1:2]] <= exmem_wdata_q;
      end
   end

   assign pc_out              = pc_q;
   assign IFID_pc4            = ifid_pc4_q;
   assign IFID_inst           = ifid_inst_q;
   assign ID_alu_op           = id_aluop;
   assign IDEX_pc4            = idex_pc4_q;
   assign IDEX_ReadData1      = idex_rd1_q;
   assign IDEX_ReadData2      = idex_rd2_q;
   assign IDEX_SignExtend     = idex_sext_q;
   assign IDEX_inst25_21      = idex_rs_q;
   assign IDEX_inst20_16      = idex_rt_q;
   assign IDEX_inst15_11      = idex_rd_q;
   assign fu_mem_RegWrite     = exmem_regwrite_q;
   assign fu_wb_RegWrite      = memwb_regwrite_q;
   assign fu_ex_instr25_21    = idex_rs_q;
   assign fu_ex_instr20_16    = idex_rt_q;
   assign fu_mem_instr15_11   = exmem_wreg_q;
   assign fu_wb_instr15_11    = memwb_wreg_q;
   assign EX_alu_op           = idex_aluop_q;
   assign ForwardA            = fwd_a;
   assign ForwardB            = fwd_b;
   assign alu_ctrl            = ex_ctrl;
   assign ALU_input1          = fwd_a_val;
   assign ALU_input2          = alu_in2;
   assign EXMEM_PC_beq        = exmem_pcbeq_q;
   assign EXMEM_alu_result    = exmem_alu_q;
   assign EXMEM_ReadData2     = exmem_wdata_q;
   assign EXMEM_WriteRegister = exmem_wreg_q;
   assign MEMWB_ReadData      = memwb_rdata_q;
   assign MEMWB_alu_result    = memwb_alu_q;
   assign MEMWB_WriteRegister = memwb_wreg_q;
endmodule

// File: tb/tb_mips32.sv
// Bench for mips32: programs are poked into the ROM, expected register writebacks are queued
// and matched against each WB retirement, plus point checks on pipeline debug outputs.
module tb_mips32;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] IFID_pc4, IFID_inst;
   logic [1:0]  ID_alu_op;
   logic [31:0] IDEX_pc4, IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExtend;
   logic [4:0]  IDEX_inst25_21, IDEX_inst20_16, IDEX_inst15_11;
   logic        fu_mem_RegWrite, fu_wb_RegWrite;
   logic [4:0]  fu_ex_instr25_21, fu_ex_instr20_16, fu_mem_instr15_11, fu_wb_instr15_11;
   logic [1:0]  EX_alu_op, ForwardA, ForwardB;
   logic [3:0]  alu_ctrl;
   logic [31:0] ALU_input1, ALU_input2;
   logic [31:0] EXMEM_PC_beq, EXMEM_alu_result, EXMEM_ReadData2;
   logic [4:0]  EXMEM_WriteRegister;
   logic [31:0] MEMWB_ReadData, MEMWB_alu_result;
   logic [4:0]  MEMWB_WriteRegister;
   logic [31:0] pc_out;

   mips32 #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .IMEM_FILE("")) dut (
      .clk(clk), .reset(reset),
      .IFID_pc4(IFID_pc4), .IFID_inst(IFID_inst), .ID_alu_op(ID_alu_op),
      .IDEX_pc4(IDEX_pc4), .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2),
      .IDEX_SignExtend(IDEX_SignExtend), .IDEX_inst25_21(IDEX_inst25_21),
      .IDEX_inst20_16(IDEX_inst20_16), .IDEX_inst15_11(IDEX_inst15_11),
      .fu_mem_RegWrite(fu_mem_RegWrite), .fu_wb_RegWrite(fu_wb_RegWrite),
      .fu_ex_instr25_21(fu_ex_instr25_21), .fu_ex_instr20_16(fu_ex_instr20_16),
      .fu_mem_instr15_11(fu_mem_instr15_11), .fu_wb_instr15_11(fu_wb_instr15_11),
      .EX_alu_op(EX_alu_op), .ForwardA(ForwardA), .ForwardB(ForwardB), .alu_ctrl(alu_ctrl),
      .ALU_input1(ALU_input1), .ALU_input2(ALU_input2),
      .EXMEM_PC_beq(EXMEM_PC_beq), .EXMEM_alu_result(EXMEM_alu_result),
      .EXMEM_ReadData2(EXMEM_ReadData2), .EXMEM_WriteRegister(EXMEM_WriteRegister),
      .MEMWB_ReadData(MEMWB_ReadData), .MEMWB_alu_result(MEMWB_alu_result),
      .MEMWB_WriteRegister(MEMWB_WriteRegister), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } wb_t;

   wb_t sb_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  mon_en  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic push(input logic [4:0] rd, input logic [31:0] val);
      wb_t e;
      e.rd  = rd;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
   endtask

   // Every non-$0 writeback retiring in WB must match the next queued expectation
   always @(negedge clk) begin : monitor
      wb_t e;
      if (mon_en && reset && fu_wb_RegWrite && MEMWB_WriteRegister != 5'd0) begin
         if (sb_q.size() == 0) begin
            check("sb_extra_wb", 32'(MEMWB_WriteRegister), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("wb_rd", 32'(MEMWB_WriteRegister), 32'(e.rd));
            check("wb_val", dut.wb_data, e.val);
         end
      end
   end

   initial begin
      #1 reset = 1'b0;
      #1;
      check("rst_pc", pc_out, 32'd0);
      check("rst_ifid_inst", IFID_inst, 32'd0);
      check("rst_exmem_alu", EXMEM_alu_result, 32'd0);
      check("rst_memwb_wreg", 32'(MEMWB_WriteRegister), 32'd0);

      // Program 1: ALU ops and forwarding
      clear_rom();
      dut.imem[0] = r_op(5'd1, 5'd2, 5'd3, 6'h20);      // add $3,$1,$2
      dut.imem[1] = r_op(5'd3, 5'd1, 5'd4, 6'h22);      // sub $4,$3,$1  (EX/MEM fwd)
      dut.imem[2] = r_op(5'd3, 5'd1, 5'd10, 6'h22);     // sub $10,$3,$1 (MEM/WB fwd)
      dut.imem[3] = r_op(5'd2, 5'd1, 5'd7, 6'h2A);      // slt $7,$2,$1
      dut.imem[4] = r_op(5'd1, 5'd2, 5'd7, 6'h2A);      // slt $7,$1,$2
      dut.imem[5] = r_op(5'd1, 5'd7, 5'd13, 6'h25);     // or  $13,$1,$7
      dut.imem[6] = r_op(5'd1, 5'd2, 5'd14, 6'h22);     // sub $14,$1,$2 = -1
      dut.imem[7] = r_op(5'd14, 5'd0, 5'd15, 6'h2A);    // slt $15,$14,$0
      dut.imem[8] = i_op(6'h3F, 5'd1, 5'd3, 16'h0000);  // unknown opcode
      dut.imem[9] = r_op(5'd1, 5'd2, 5'd0, 6'h20);      // add $0,$1,$2
      push(5'd3, 32'd3);
      push(5'd4, 32'd2);
      push(5'd10, 32'd2);
      push(5'd7, 32'd0);
      push(5'd7, 32'd1);
      push(5'd13, 32'd1);
      push(5'd14, 32'hFFFF_FFFF);
      push(5'd15, 32'd1);
      mon_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;

      run(1);
      check("p1_pc_e1", pc_out, 32'd4);
      check("p1_ifid_inst", IFID_inst, r_op(5'd1, 5'd2, 5'd3, 6'h20));
      run(1);
      check("p1_pc_e2", pc_out, 32'd8);
      check("p1_idex_rd1", IDEX_ReadData1, 32'd1);
      check("p1_idex_rd2", IDEX_ReadData2, 32'd2);
      check("p1_id_aluop", 32'(ID_alu_op), 32'd2);
      run(1);
      check("p1_add_res", EXMEM_alu_result, 32'd3);
      check("p1_fwdA_exmem", 32'(ForwardA), 32'd2);
      check("p1_alu_in1_e3", ALU_input1, 32'd3);
      check("p1_alu_ctrl_sub", 32'(alu_ctrl), 32'b0110);
      check("p1_fu_mem_rw", 32'(fu_mem_RegWrite), 32'd1);
      run(1);
      check("p1_sub_res", EXMEM_alu_result, 32'd2);
      check("p1_memwb_wreg", 32'(MEMWB_WriteRegister), 32'd3);
      check("p1_fwdA_memwb", 32'(ForwardA), 32'd1);
      check("p1_alu_in1_e4", ALU_input1, 32'd3);
      run(14);
      check("p1_sb_left", 32'(sb_q.size()), 32'd0);
      check("p1_reg0", dut.rf_q[0], 32'd0);
      check("p1_reg3", dut.rf_q[3], 32'd3);

      // Asynchronous reset mid-run
      #3 reset = 1'b0;
      #1;
      check("mid_rst_pc", pc_out, 32'd0);
      check("mid_rst_ifid_pc4", IFID_pc4, 32'd0);
      check("mid_rst_reg4", dut.rf_q[4], 32'd4);
      check("mid_rst_reg14", dut.rf_q[14], 32'd14);

      // Program 2: loads, stores, store-data forwarding
      clear_rom();
      dut.imem[0] = i_op(6'h23, 5'd0, 5'd5, 16'd8);     // lw  $5,8($0)
      dut.imem[1] = i_op(6'h2B, 5'd0, 5'd2, 16'd12);    // sw  $2,12($0)
      dut.imem[2] = i_op(6'h23, 5'd0, 5'd6, 16'd12);    // lw  $6,12($0)
      dut.imem[3] = i_op(6'h23, 5'd0, 5'd16, 16'd16);   // lw  $16,16($0)
      dut.imem[4] = r_op(5'd1, 5'd2, 5'd17, 6'h20);     // add $17,$1,$2
      dut.imem[5] = i_op(6'h2B, 5'd0, 5'd17, 16'd20);   // sw  $17,20($0)
      dut.imem[6] = i_op(6'h23, 5'd0, 5'd18, 16'd20);   // lw  $18,20($0)
      push(5'd5, 32'd2);
      push(5'd6, 32'd2);
      push(5'd16, 32'd4);
      push(5'd17, 32'd3);
      push(5'd18, 32'd3);
      @(negedge clk);
      reset = 1'b1;
      run(1);
      check("p2_pc_e1", pc_out, 32'd4);
      run(1);
      check("p2_pc_e2", pc_out, 32'd8);
      check("p2_lw_alu_in2", ALU_input2, 32'd8);
      run(2);
      check("p2_lw_rdata", MEMWB_ReadData, 32'd2);
      run(14);
      check("p2_sb_left", 32'(sb_q.size()), 32'd0);
      check("p2_dmem3", dut.dmem_q[3], 32'd2);
      check("p2_dmem5", dut.dmem_q[5], 32'd3);

      // Program 3: taken and not-taken branches with three retiring slots
      #3 reset = 1'b0;
      #1;
      check("p3_rst_dmem3", dut.dmem_q[3], 32'd3);
      clear_rom();
      dut.imem[0]  = i_op(6'h04, 5'd1, 5'd1, 16'd4);    // beq $1,$1,+4 -> 20
      dut.imem[1]  = r_op(5'd1, 5'd1, 5'd20, 6'h20);
      dut.imem[2]  = r_op(5'd2, 5'd2, 5'd21, 6'h20);
      dut.imem[3]  = r_op(5'd1, 5'd2, 5'd22, 6'h20);
      dut.imem[4]  = r_op(5'd1, 5'd1, 5'd24, 6'h20);    // skipped by the branch
      dut.imem[5]  = r_op(5'd2, 5'd1, 5'd23, 6'h20);
      dut.imem[6]  = i_op(6'h04, 5'd1, 5'd2, 16'd8);    // beq $1,$2 not taken
      dut.imem[7]  = r_op(5'd1, 5'd1, 5'd25, 6'h20);
      dut.imem[8]  = r_op(5'd1, 5'd2, 5'd27, 6'h20);
      dut.imem[11] = r_op(5'd2, 5'd2, 5'd26, 6'h20);
      push(5'd20, 32'd2);
      push(5'd21, 32'd4);
      push(5'd22, 32'd3);
      push(5'd23, 32'd3);
      push(5'd25, 32'd2);
      push(5'd27, 32'd3);
      push(5'd26, 32'd4);
      @(negedge clk);
      reset = 1'b1;
      run(3);
      check("p3_beq_target", EXMEM_PC_beq, 32'd20);
      run(1);
      check("p3_pc_taken", pc_out, 32'd20);
      run(4);
      check("p3_beq2_target", EXMEM_PC_beq, 32'd60);
      run(1);
      check("p3_pc_not_taken", pc_out, 32'd40);
      run(11);
      check("p3_sb_left", 32'(sb_q.size()), 32'd0);
      check("p3_reg24", dut.rf_q[24], 32'd24);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
